alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Round-robin scheduler that shares one 8-bit ALU (add/sub/mul/div, 16-bit result, divide-by-zero error flag) between two requesters.
- Accepts one command at a time via valid/ready, drives the ALU operands for a per-op latency, captures result and error, and returns a tagged response with backpressure.
- Sits between the requesting datapath blocks and the ALU instance.
- Keeps a saturating count of divide-by-zero errors.

Parameters:
- MUL_CYCLES, 2, EXEC cycles for op 2'b10; legal range 1..15.
- DIV_CYCLES, 4, EXEC cycles for op 2'b11; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester command valid; bit i = requester i.
- req_a0, req_b0  in  8 each  requester 0 operands.
- req_op0  in  2  requester 0 op: 00 add, 01 sub, 10 mul, 11 div.
- req_a1, req_b1  in  8 each  requester 1 operands.
- req_op1  in  2  requester 1 op.
- req_ready  out  2  per-requester accept; one-hot or zero.
- alu_a, alu_b  out  8 each  operands to the ALU.
- alu_op  out  2  op to the ALU.
- alu_result  in  16  ALU result.
- alu_error  in  1  ALU divide-by-zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  16  captured result.
- rsp_error  out  1  captured error.
- busy  out  1  high whenever state != IDLE.
- err_count  out  8  saturating count of responses with error=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_error=0; err_count=0; operand regs=0; alu_a/alu_b/alu_op=0; last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation drops the in-flight command and response without emitting anything.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Only requester i valid: grant i.
  - Both valid: grant !last_grant.
  - req_ready[g]=1 combinationally in IDLE for the granted requester only; req_ready=0 in all other states.
- IDLE, on accept (req_valid[g] & req_ready[g]):
  - Latch a, b, op, id=g; set last_grant=g.
  - Load cnt = L-1, where L=1 for add/sub, MUL_CYCLES for mul, DIV_CYCLES for div.
  - Go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op driven from the latched regs, held stable throughout.
  - Each cycle with cnt!=0: decrement cnt.
  - When cnt==0: capture alu_result into rsp_result and alu_error into rsp_error, set rsp_valid=1, go to RESP.
  - If the captured error is 1 and err_count<255, increment err_count.
- Latency: accept at cycle T → EXEC spans cycles T+1..T+L → rsp_valid first high at T+L+1.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_error held stable until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE. No new accept in the same cycle; next accept is earliest at handshake+1.
- Outside EXEC, alu_* hold the last latched operands. Results are only sampled in EXEC.
- Widths:
  - The block does no arithmetic on data; it passes the full 16-bit ALU result, including wrap/borrow bits from add/sub.
  - Divide by zero returns whatever the ALU reports (0 with error=1); the scheduler does not special-case it.
- Simultaneous events:
  - A requester deasserting valid in IDLE before accept is legal and gets no grant.
  - Valid held through RESP is not accepted until IDLE.
  - err_count saturates at 255 and never wraps.
- busy=1 in EXEC and RESP.

Test Plan:
- Single add: req0 a=200, b=100, op=00 with rsp_ready=1 → accept at T, rsp_valid at T+2, rsp_id=0, rsp_result=16'd300, rsp_error=0; busy high T+1..T+2.
- Tie alternation: both valid continuously, req0 op=10 a=15 b=17, req1 op=01 a=5 b=10, rsp_ready=1 → grants 0,1,0,1.
  - id0 results are 255, rsp_valid 3 cycles after accept.
  - id1 results are 16'hFFFB.
- Divide latency and error: req1 a=100, b=0, op=11, DIV_CYCLES=4 → rsp_valid at T+5, rsp_result=0, rsp_error=1, err_count 0→1.
  - Then a=100, b=7 → rsp_result=14, rsp_error=0, err_count stays 1.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid with req0 still valid → rsp fields stable, req_ready=0 throughout.
  - Raise rsp_ready → handshake, then req0 accepted the following cycle.
- Reset mid-EXEC: start div, assert rst_n=0 at T+2 → immediately rsp_valid=0, busy=0, err_count=0.
  - After release, a tie grants requester 0 first.
- Saturation: 260 divide-by-zero commands → err_count stops at 255.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one 8-bit ALU between two requesters.
//
// Accepts one command at a time through a per-requester valid/ready handshake,
// drives the ALU operands for an op-dependent number of cycles, captures the
// 16-bit result and the divide-by-zero flag, and returns a tagged response
// that is held until the consumer accepts it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]             per-requester command valid
//   req_a0/req_b0/req_op0      requester 0 operands and op (00 add, 01 sub, 10 mul, 11 div)
//   req_a1/req_b1/req_op1      requester 1 operands and op
//   req_ready[1:0]             per-requester accept (one-hot or zero, IDLE only)
//   alu_a/alu_b/alu_op         operands and op presented to the ALU
//   alu_result, alu_error      ALU result and divide-by-zero flag
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_result,        requester index, captured result, captured error
//   rsp_error
//   busy                       high while a command is executing or awaiting rsp_ready
//   err_count                  saturating count of responses carrying error=1
module alu_sched #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_a0,
    input  logic [7:0]  req_b0,
    input  logic [1:0]  req_op0,
    input  logic [7:0]  req_a1,
    input  logic [7:0]  req_b1,
    input  logic [1:0]  req_op1,
    output logic [1:0]  req_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_error_q, rsp_error_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        grant;
    logic        accept;
    logic [1:0]  sel_op;

    // EXEC length minus one, so cnt==0 marks the capture cycle.
    function automatic logic [3:0] lat_m1(input logic [1:0] op);
        case (op)
            2'b10:   lat_m1 = 4'(MUL_CYCLES - 1);
            2'b11:   lat_m1 = 4'(DIV_CYCLES - 1);
            default: lat_m1 = 4'd0;
        endcase
    endfunction

    // Arbitration: a lone requester always wins; on a tie the one not granted
    // last time wins. Grant only matters while IDLE.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept    = (state_q == IDLE) && (req_valid != 2'b00);
        sel_op    = grant ? req_op1 : req_op0;
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = grant ? req_a1 : req_a0;
                    b_d          = grant ? req_b1 : req_b0;
                    op_d         = sel_op;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = lat_m1(sel_op);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_error_d  = alu_error;
                    rsp_valid_d  = 1'b1;
                    if (alu_error && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            err_count_q  <= err_count_d;
        end
    end

    // Operand registers feed the ALU directly, so they hold the last command
    // outside EXEC as well.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign busy       = (state_q != IDLE);
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

    localparam int unsigned MUL_C = 2;
    localparam int unsigned DIV_C = 4;
    localparam int INF = 32'h7fffffff;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  req_ready;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_error;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
    logic [15:0] rsp_result;
    logic [7:0]  err_count;

    alu_sched #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy),
        .err_count(err_count)
    );

    // ALU environment seen by the DUT.
    always_comb begin
        alu_error = 1'b0;
        case (alu_op)
            2'b00: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            2'b01: alu_result = {8'h00, alu_a} - {8'h00, alu_b};
            2'b10: alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: begin
                if (alu_b == 8'h00) begin
                    alu_result = 16'h0000;
                    alu_error  = 1'b1;
                end else begin
                    alu_result = {8'h00, alu_a / alu_b};
                end
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        int         acc;
    } txn_t;

    txn_t q[$];
    int   idle_from = 0;      // first cycle in which the scheduler can accept again
    logic last_m    = 1'b1;
    int   err_m     = 0;
    logic head_seen = 1'b0;
    logic [1:0] acc_flag = 2'b00;

    function automatic int lat(input logic [1:0] op);
        if (op == 2'b10) return int'(MUL_C);
        if (op == 2'b11) return int'(DIV_C);
        return 1;
    endfunction

    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ia = a;
        int unsigned ib = b;
        case (op)
            2'b00: return 16'(ia + ib);
            2'b01: return 16'(ia - ib);
            2'b10: return 16'(ia * ib);
            default: return (ib == 0) ? 16'd0 : 16'(ia / ib);
        endcase
    endfunction

    // Stimulus side of the model: predicts grants and pushes expected responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (idle_from <= cyc) begin
                check("busy_idle", 32'(busy), 32'd0);
                if (req_valid != 2'b00) begin
                    txn_t t;
                    logic g;
                    g = (req_valid == 2'b11) ? !last_m : req_valid[1];
                    check("req_ready_grant", 32'(req_ready), g ? 32'd2 : 32'd1);
                    t.id  = g;
                    t.a   = g ? req_a1 : req_a0;
                    t.b   = g ? req_b1 : req_b0;
                    t.op  = g ? req_op1 : req_op0;
                    t.acc = cyc;
                    q.push_back(t);
                    last_m      = g;
                    acc_flag[g] = 1'b1;
                    idle_from   = INF;
                end else begin
                    check("req_ready_none", 32'(req_ready), 32'd0);
                end
            end else begin
                check("busy_active", 32'(busy), 32'd1);
                check("req_ready_busy", 32'(req_ready), 32'd0);
            end
        end
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() == 0) begin
                if (rsp_valid) check("rsp_valid_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                txn_t h;
                int   exp_first;
                h = q[0];
                exp_first = h.acc + lat(h.op) + 1;
                if (cyc > h.acc) begin
                    check("alu_a", 32'(alu_a), 32'(h.a));
                    check("alu_b", 32'(alu_b), 32'(h.b));
                    check("alu_op", 32'(alu_op), 32'(h.op));
                end
                if (!head_seen) begin
                    if (rsp_valid) begin
                        check("rsp_latency", 32'(cyc), 32'(exp_first));
                        head_seen = 1'b1;
                        if (h.op == 2'b11 && h.b == 8'h00 && err_m < 255) err_m++;
                        check("err_count", 32'(err_count), 32'(err_m));
                    end else if (cyc == exp_first) begin
                        check("rsp_late", 32'(rsp_valid), 32'd1);
                    end
                end
                if (head_seen) begin
                    check("rsp_valid_held", 32'(rsp_valid), 32'd1);
                    check("rsp_id", 32'(rsp_id), 32'(h.id));
                    check("rsp_result", 32'(rsp_result), 32'(ref_result(h.op, h.a, h.b)));
                    check("rsp_error", 32'(rsp_error), 32'(h.op == 2'b11 && h.b == 8'h00));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        head_seen = 1'b0;
                        idle_from = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        if (i == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_acc(input int i);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!acc_flag[i] && n < 200);
        if (!acc_flag[i]) timeout_fail("accept_wait");
        acc_flag[i]  = 1'b0;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        rsp_ready = 1'b1;
        while ((q.size() != 0 || idle_from > cyc) && n < 300) begin
            tick();
            n++;
        end
        if (q.size() != 0 || idle_from > cyc) timeout_fail("idle_wait");
        acc_flag = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts;
        int n;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = '0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", {14'd0, alu_op, alu_a, alu_b}, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Tie alternation: requester 0 wins first after reset.
        set_req(0, 8'd15, 8'd17, 2'b10);
        set_req(1, 8'd5, 8'd10, 2'b01);
        accepts = 0;
        n = 0;
        while (accepts < 4 && n < 200) begin
            tick();
            n++;
            for (int unsigned i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin
                    acc_flag[i] = 1'b0;
                    accepts++;
                end
            end
        end
        if (accepts < 4) timeout_fail("tie_accepts");
        req_valid = 2'b00;
        wait_idle();

        // Single add with 16-bit carry out.
        set_req(0, 8'd200, 8'd100, 2'b00);
        wait_acc(0);
        wait_idle();

        // Divide by zero, then a normal divide.
        set_req(1, 8'd100, 8'd0, 2'b11);
        wait_acc(1);
        wait_idle();
        set_req(1, 8'd100, 8'd7, 2'b11);
        wait_acc(1);
        wait_idle();

        // Backpressure with requester 0 still waiting.
        rsp_ready = 1'b0;
        set_req(0, 8'd1, 8'd2, 2'b00);
        wait_acc(0);
        set_req(0, 8'd3, 8'd4, 2'b10);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) timeout_fail("bp_rsp_valid");
        repeat (6) tick();
        rsp_ready = 1'b1;
        wait_acc(0);
        wait_idle();

        // Randomised traffic with random backpressure and withdrawn requests.
        for (int unsigned c = 0; c < 600; c++) begin
            tick();
            rsp_ready = ($urandom % 4) != 0;
            for (int unsigned i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin
                    acc_flag[i]  = 1'b0;
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && ($urandom % 10) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && ($urandom % 3) == 0) begin
                    set_req(int'(i), 8'($urandom), (($urandom % 4) == 0) ? 8'd0 : 8'($urandom),
                            2'($urandom));
                end
            end
        end
        req_valid = 2'b00;
        wait_idle();

        // Reset in the middle of a divide.
        set_req(1, 8'd100, 8'd0, 2'b11);
        wait_acc(1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        q.delete();
        idle_from = 0;
        last_m    = 1'b1;
        err_m     = 0;
        head_seen = 1'b0;
        acc_flag  = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 8'd9, 8'd3, 2'b00);
        set_req(1, 8'd9, 8'd3, 2'b01);
        n = 0;
        while (acc_flag == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        if (acc_flag == 2'b00) timeout_fail("post_reset_grant");
        req_valid = 2'b00;
        acc_flag  = 2'b00;
        wait_idle();

        // Saturation of the error counter.
        for (int unsigned k = 0; k < 260; k++) begin
            set_req(0, 8'($urandom), 8'd0, 2'b11);
            wait_acc(0);
        end
        wait_idle();
        check("err_count_saturated", 32'(err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
